// File: rtl/mul_seq_ctrl_pkg.sv
// Shared control package for the accumulator/ALU datapath and its sequencers.
// Holds the nibble mode encoding, the sequencer state type and the strobe decoder.
package acc_ctl_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOADH = 3'd1,
    ST_XFER  = 3'd2,
    ST_CLRH  = 3'd3,
    ST_ADD   = 3'd4,
    ST_SHIFT = 3'd5,
    ST_DONE  = 3'd6
  } seq_state_t;

  typedef struct packed {
    logic  busy;
    logic  done;
    logic  ah_inen;
    logic  ah_reset;
    mode_t hs;
    mode_t ls;
    logic  s_mul;
    logic  acc_oen;
  } strobe_t;

  // Datapath strobes belonging to a state; at most one of ah_inen/ah_reset/s_mul is set.
  function automatic strobe_t decode_state(seq_state_t st);
    strobe_t s;
    s      = '0;
    s.busy = (st != ST_IDLE);
    case (st)
      ST_LOADH: begin
        s.ah_inen = 1'b1;
        s.hs      = MODE_LOAD;
      end
      ST_XFER:  s.ls = MODE_LOAD;
      ST_CLRH:  s.ah_reset = 1'b1;
      ST_ADD: begin
        s.hs    = MODE_LOAD;
        s.s_mul = 1'b1;
      end
      ST_SHIFT: begin
        s.hs = MODE_SHR;
        s.ls = MODE_SHR;
      end
      ST_DONE: begin
        s.done    = 1'b1;
        s.acc_oen = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Control bundle between the multiply sequencer and the decoder/aluNacc side.
// master = sequencer (drives strobes), slave = decoder and datapath.
interface mul_seq_ctrl_if;
  logic       start;
  logic       stall;
  logic       busy;
  logic       done;
  logic       ah_inen;
  logic       ah_reset;
  logic [1:0] hs;
  logic [1:0] ls;
  logic       s_mul;
  logic       s_add;
  logic       s_sub;
  logic       s_and;
  logic       s_div;
  logic       acc_oen;

  modport master (
    input  start, stall,
    output busy, done, ah_inen, ah_reset, hs, ls,
    output s_mul, s_add, s_sub, s_and, s_div, acc_oen
  );

  modport slave (
    output start, stall,
    input  busy, done, ah_inen, ah_reset, hs, ls,
    input  s_mul, s_add, s_sub, s_and, s_div, acc_oen
  );
endinterface

// File: rtl/mul_seq_ctrl_iter_counter.sv
// Add/shift iteration counter with synchronous clear and a freeze input.
// Saturates at NBITS so it can never wrap inside one multiply.
module iter_counter #(
  parameter int NBITS = 4
) (
  input  logic clk,
  input  logic clr_n,
  input  logic clr,
  input  logic inc,
  input  logic hold,
  output logic last
);

  localparam int CW = $clog2(NBITS + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(NBITS - 1);
  localparam logic [CW-1:0] MAX_COUNT  = CW'(NBITS);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count_reg <= '0;
    end else if (!hold) begin
      if (clr) begin
        count_reg <= '0;
      end else if (inc && (count_reg != MAX_COUNT)) begin
        count_reg <= count_reg + CW'(1);
      end
    end
  end

  assign last = (count_reg == LAST_COUNT);

endmodule

// File: rtl/mul_seq_ctrl.sv
// Shift-and-add multiply sequencer driving the aluNacc control strobes.
// State and strobes are registered; stall blanks the strobes and freezes progress.
module mul_seq_ctrl
  import acc_ctl_pkg::*;
#(
  parameter int NBITS = 4
) (
  input  logic           clk,
  input  logic           clr_n,
  mul_seq_ctrl_if.master ctl
);

  seq_state_t state_reg;
  seq_state_t state_next;
  strobe_t    strobe_reg;
  strobe_t    strobe_out;
  logic       last;
  logic       cnt_clr;
  logic       cnt_inc;

  // Counter moves only on the cycle its state actually exits, so stall must freeze it too.
  assign cnt_clr = (state_reg == ST_CLRH);
  assign cnt_inc = (state_reg == ST_SHIFT);

  iter_counter #(
    .NBITS (NBITS)
  ) u_iter_counter (
    .clk   (clk),
    .clr_n (clr_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .hold  (ctl.stall),
    .last  (last)
  );

  always_comb begin
    state_next = state_reg;
    if (!ctl.stall) begin
      unique case (state_reg)
        ST_IDLE:  if (ctl.start) state_next = ST_LOADH;
        ST_LOADH: state_next = ST_XFER;
        ST_XFER:  state_next = ST_CLRH;
        ST_CLRH:  state_next = ST_ADD;
        ST_ADD:   state_next = ST_SHIFT;
        ST_SHIFT: state_next = last ? ST_DONE : ST_ADD;
        ST_DONE:  state_next = ctl.start ? ST_LOADH : ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_reg  <= ST_IDLE;
      strobe_reg <= '0;
    end else begin
      state_reg  <= state_next;
      strobe_reg <= decode_state(state_next);
    end
  end

  // A stalled cycle issues nothing; the held state's strobes reappear once stall drops.
  always_comb begin
    strobe_out = strobe_reg;
    if (ctl.stall) begin
      strobe_out      = '0;
      strobe_out.busy = strobe_reg.busy;
    end
  end

  assign ctl.busy     = strobe_out.busy;
  assign ctl.done     = strobe_out.done;
  assign ctl.ah_inen  = strobe_out.ah_inen;
  assign ctl.ah_reset = strobe_out.ah_reset;
  assign ctl.hs       = strobe_out.hs;
  assign ctl.ls       = strobe_out.ls;
  assign ctl.s_mul    = strobe_out.s_mul;
  assign ctl.acc_oen  = strobe_out.acc_oen;
  assign ctl.s_add    = 1'b0;
  assign ctl.s_sub    = 1'b0;
  assign ctl.s_and    = 1'b0;
  assign ctl.s_div    = 1'b0;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: a behavioural aluNacc model follows the strobes and a
// scoreboard of expected products/latencies is checked at every done pulse.
module tb_mul_seq_ctrl;
  localparam int NBITS = 4;
  localparam int LAT   = 3 + 2 * NBITS;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] prod;
    int         start_cycle;
    int         lat;
  } sb_item_t;

  logic       clk   = 1'b0;
  logic       clr_n = 1'b0;
  logic [3:0] bus_in = '0;
  logic [3:0] breg   = '0;
  int         cycle_cnt = 0;
  int         n_checks  = 0;
  int         n_errors  = 0;
  sb_item_t   sb[$];

  // aluNacc model state and monitor scratch
  logic [3:0]  ah = '0;
  logic [3:0]  al = '0;
  logic        cy = 1'b0;
  logic [3:0]  ah_n, al_n;
  logic        cy_n;
  logic [4:0]  sum;
  logic [2:0]  code;
  logic [63:0] trace_sig = '0;
  sb_item_t    item;

  mul_seq_ctrl_if bus();

  mul_seq_ctrl #(.NBITS(NBITS)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .ctl   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] outs_vec();
    return {bus.busy, bus.done, bus.ah_inen, bus.ah_reset, bus.hs, bus.ls,
            bus.s_mul, bus.s_add, bus.s_sub, bus.s_and, bus.s_div, bus.acc_oen};
  endfunction

  // 1 LOADH, 2 XFER, 3 CLRH, 4 ADD, 5 SHIFT, 6 DONE, 0 blank, 7 illegal combination
  function automatic logic [2:0] strobe_code();
    logic [13:0] v;
    v = outs_vec();
    v[13] = 1'b0;
    case (v)
      14'b0_0_1_0_11_00_0_0000_0: return 3'd1;
      14'b0_0_0_0_00_11_0_0000_0: return 3'd2;
      14'b0_0_0_1_00_00_0_0000_0: return 3'd3;
      14'b0_0_0_0_11_00_1_0000_0: return 3'd4;
      14'b0_0_0_0_01_01_0_0000_0: return 3'd5;
      14'b0_1_0_0_00_00_0_0000_1: return 3'd6;
      14'b0_0_0_0_00_00_0_0000_0: return 3'd0;
      default:                    return 3'd7;
    endcase
  endfunction

  function automatic logic [63:0] exp_sig(input int n);
    logic [63:0] s;
    s = '0;
    s = {s[60:0], 3'd1};
    s = {s[60:0], 3'd2};
    s = {s[60:0], 3'd3};
    for (int i = 0; i < n; i++) begin
      s = {s[60:0], 3'd4};
      s = {s[60:0], 3'd5};
    end
    s = {s[60:0], 3'd6};
    return s;
  endfunction

  // Monitor: sampled on the falling edge, while all DUT outputs and bench inputs are stable.
  always @(negedge clk) begin
    if (!clr_n) begin
      trace_sig = '0;
    end else begin
      code = strobe_code();
      if (code != 3'd0) trace_sig = {trace_sig[60:0], code};
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          item = sb.pop_front();
          $display("op %h x %h: acc_out=%h expected=%h latency=%0d (expected %0d)",
                   item.a, item.b, {ah, al}, item.prod, cycle_cnt - item.start_cycle, item.lat);
          check("product", {56'd0, ah, al}, {56'd0, item.prod});
          check("latency", 64'(cycle_cnt - item.start_cycle), 64'(item.lat));
          check("strobe_order", trace_sig, exp_sig(NBITS));
        end
        trace_sig = '0;
      end
      ah_n = ah;
      al_n = al;
      cy_n = cy;
      if (bus.ah_reset) begin
        ah_n = '0;
        cy_n = 1'b0;
      end
      if (bus.hs == 2'b11 && bus.ah_inen) begin
        ah_n = bus_in;
        cy_n = 1'b0;
      end
      if (bus.hs == 2'b11 && bus.s_mul && al[0]) begin
        sum  = {1'b0, ah} + {1'b0, breg};
        ah_n = sum[3:0];
        cy_n = sum[4];
      end
      if (bus.ls == 2'b11) al_n = ah;
      if (bus.hs == 2'b01 && bus.ls == 2'b01) begin
        al_n = {ah[0], al[3:1]};
        ah_n = {cy, ah[3:1]};
        cy_n = 1'b0;
      end
      ah = ah_n;
      al = al_n;
      cy = cy_n;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_op(input logic [3:0] a, input logic [3:0] b, input int lat);
    sb_item_t it;
    it.a           = a;
    it.b           = b;
    it.prod        = {4'd0, a} * {4'd0, b};
    it.start_cycle = cycle_cnt + 1;
    it.lat         = lat;
    sb.push_back(it);
  endtask

  task automatic start_op(input logic [3:0] a, input logic [3:0] b, input int lat);
    bus_in    = a;
    breg      = b;
    bus.start = 1'b1;
    push_op(a, b, lat);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("done_timeout", 64'(sb.size()), 64'd0);
    sb.delete();
    tick();
  endtask

  initial begin
    bit seen;
    bus.start = 1'b0;
    bus.stall = 1'b0;

    // reset held for two cycles, then idle with start low
    clr_n = 1'b0;
    repeat (2) begin
      tick();
      check("reset_outs", {50'd0, outs_vec()}, 64'd0);
    end
    clr_n = 1'b1;
    repeat (5) begin
      tick();
      check("idle_outs", {50'd0, outs_vec()}, 64'd0);
    end

    start_op(4'h3, 4'h5, LAT);
    wait_done(40);
    start_op(4'hF, 4'hF, LAT);
    wait_done(40);
    start_op(4'h0, 4'h9, LAT);
    wait_done(40);

    // back-to-back: start held high through DONE
    bus_in    = 4'h6;
    breg      = 4'h7;
    bus.start = 1'b1;
    push_op(4'h6, 4'h7, LAT);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (bus.done) seen = 1'b1;
    end
    check("b2b_first_done", {63'd0, seen}, 64'd1);
    push_op(4'h6, 4'h7, LAT);
    tick();
    bus.start = 1'b0;
    wait_done(40);

    // stall for three cycles starting at the second ADD
    start_op(4'hA, 4'hD, LAT + 3);
    repeat (5) tick();
    bus.stall = 1'b1;
    #1;
    check("stall_outs", {50'd0, outs_vec()}, 64'h2000);
    repeat (2) begin
      tick();
      check("stall_outs", {50'd0, outs_vec()}, 64'h2000);
    end
    tick();
    bus.stall = 1'b0;
    wait_done(40);

    // reset during the third SHIFT abandons the operation
    start_op(4'h9, 4'h7, LAT);
    repeat (8) tick();
    clr_n = 1'b0;
    tick();
    check("midreset_outs", {50'd0, outs_vec()}, 64'd0);
    sb.delete();
    clr_n = 1'b1;
    tick();
    start_op(4'hC, 4'hB, LAT);
    wait_done(40);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
